// File: rtl/fetch_queue_pkg.sv
// Shared types for the fetch stage: machine word, opcode field and queued fetch entry.
// The halt opcode is what stops the fetcher.
package fetch_queue_pkg;

   typedef logic [31:0] word_t;
   typedef logic [5:0]  opcode_t;

   localparam opcode_t HALT_OP = 6'b111111;

   typedef struct packed {
      word_t instr;
      word_t npc;
   } fetch_entry_t;

   function automatic opcode_t opcode_of(input word_t w);
      return w[31:26];
   endfunction

endpackage

// File: rtl/fetch_queue_if.sv
// Fetch-stage port bundle: PC side, icache side and the decode handshake.
// fq is the fetch queue's view, de is the decode stage's view.
interface fetch_queue_if;
   import fetch_queue_pkg::*;

   word_t imemaddr;
   word_t pc_plus_4;
   logic  ihit;
   word_t imemload;
   logic  flush;
   logic  de_ready;
   logic  imemREN;
   word_t imemaddr_o;
   logic  pc_en;
   logic  de_valid;
   word_t de_instr;
   word_t de_npc;
   logic  halted;

   modport fq (
      input  imemaddr, pc_plus_4, ihit, imemload, flush, de_ready,
      output imemREN, imemaddr_o, pc_en, de_valid, de_instr, de_npc, halted
   );

   modport de (
      input  de_valid, de_instr, de_npc, halted,
      output de_ready, flush
   );

endinterface

// File: rtl/fetch_queue_fifo.sv
// Purpose: DEPTH-entry FIFO of fetch entries with a registered head output and synchronous clear.
// Latency: a push is visible at head one cycle later; no bypass.
// Backpressure: push ignored while full, pop ignored while empty; clear beats both.
module fetch_queue_fifo
   import fetch_queue_pkg::*;
#(
   parameter int DEPTH = 2
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     clear,
   input  logic                     push,
   input  fetch_entry_t             din,
   input  logic                     pop,
   output fetch_entry_t             head,
   output logic                     full,
   output logic                     empty,
   output logic [$clog2(DEPTH):0]   count
);

   localparam int AW = $clog2(DEPTH);
   localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

   fetch_entry_t    mem [DEPTH];
   logic [AW-1:0]   wr_ptr;
   logic [AW-1:0]   rd_ptr;
   logic [AW-1:0]   rd_next;
   logic [AW:0]     count_next;
   logic            do_push;
   logic            do_pop;

   assign full    = (count == FULL_CNT);
   assign empty   = (count == '0);
   assign do_push = push & ~full & ~clear;
   assign do_pop  = pop & ~empty & ~clear;
   assign rd_next = do_pop ? rd_ptr + 1'b1 : rd_ptr;

   always_comb begin
      count_next = count;
      case ({do_push, do_pop})
         2'b10:   count_next = count + 1'b1;
         2'b01:   count_next = count - 1'b1;
         default: count_next = count;
      endcase
   end

   always_ff @(posedge clk) begin
      if (do_push) begin
         mem[wr_ptr] <= din;
      end
   end

   // Head is re-registered from the entry that will be at rd_ptr after this edge;
   // when that slot is being written this cycle, take the incoming data directly.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
         head   <= '0;
      end else if (clear) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) begin
            wr_ptr <= wr_ptr + 1'b1;
         end
         rd_ptr <= rd_next;
         count  <= count_next;
         if (count_next != '0) begin
            head <= (do_push && (wr_ptr == rd_next)) ? din : mem[rd_next];
         end
      end
   end

endmodule

// File: rtl/fetch_queue.sv
// Purpose: instruction fetch stage; issues icache reads, queues {instr, pc+4} for decode, drives pc_en.
// Latency: ihit in cycle N shows at decode in cycle N+1.
// Backpressure: request drops while the queue is full or halted; flush squashes everything.
module fetch_queue
   import fetch_queue_pkg::*;
#(
   parameter int      DEPTH   = 2,
   parameter opcode_t HALT_OP = fetch_queue_pkg::HALT_OP
) (
   input  logic       CLK,
   input  logic       nRST,
   fetch_queue_if.fq  fq
);

   localparam int AW = $clog2(DEPTH);

   logic          halted_q;
   logic          req;
   logic          push;
   logic          pop;
   logic          q_full;
   logic          q_empty;
   logic [AW:0]   q_count;
   fetch_entry_t  wr_entry;
   fetch_entry_t  head;

   // Request is forced low while reset is asserted so the icache sees no read during reset.
   assign req  = nRST & ~halted_q & ~fq.flush & ~q_full;
   assign push = req & fq.ihit;
   assign pop  = ~q_empty & fq.de_ready & ~fq.flush;

   assign wr_entry.instr = fq.imemload;
   assign wr_entry.npc   = fq.pc_plus_4;

   assign fq.imemaddr_o = fq.imemaddr;
   assign fq.imemREN    = req;
   assign fq.pc_en      = push | fq.flush;
   assign fq.de_valid   = (q_count != '0);
   assign fq.de_instr   = head.instr;
   assign fq.de_npc     = head.npc;
   assign fq.halted     = halted_q;

   always_ff @(posedge CLK or negedge nRST) begin
      if (!nRST) begin
         halted_q <= 1'b0;
      end else if (fq.flush) begin
         halted_q <= 1'b0;
      end else if (push && (opcode_of(fq.imemload) == HALT_OP)) begin
         halted_q <= 1'b1;
      end
   end

   fetch_queue_fifo #(
      .DEPTH (DEPTH)
   ) u_fifo (
      .clk   (CLK),
      .rst_n (nRST),
      .clear (fq.flush),
      .push  (push),
      .din   (wr_entry),
      .pop   (pop),
      .head  (head),
      .full  (q_full),
      .empty (q_empty),
      .count (q_count)
   );

endmodule

// File: tb/tb_fetch_queue.sv
// Bench for fetch_queue: directed cycle table, async reset check, then randomized scoreboard run.
module tb_fetch_queue;
   import fetch_queue_pkg::*;

   localparam int DEPTH = 2;

   logic CLK;
   logic nRST;
   int   checks;
   int   errors;

   fetch_queue_if bus ();

   fetch_queue #(.DEPTH(DEPTH), .HALT_OP(6'b111111)) dut (
      .CLK  (CLK),
      .nRST (nRST),
      .fq   (bus)
   );

   initial CLK = 1'b0;
   always #5 CLK = ~CLK;

   typedef struct {
      logic [31:0] addr;
      logic        ihit;
      logic [31:0] load;
      logic        flush;
      logic        rdy;
      logic        e_ren;
      logic        e_pcen;
      logic        e_vld;
      logic [31:0] e_instr;
      logic [31:0] e_npc;
      logic        e_halt;
   } vec_t;

   vec_t tbl [19];

   function automatic vec_t v(input logic [31:0] addr, input logic ihit, input logic [31:0] load,
                              input logic flush, input logic rdy, input logic ren, input logic pcen,
                              input logic vld, input logic [31:0] instr, input logic [31:0] npc,
                              input logic halt);
      vec_t r;
      r.addr = addr; r.ihit = ihit; r.load = load; r.flush = flush; r.rdy = rdy;
      r.e_ren = ren; r.e_pcen = pcen; r.e_vld = vld; r.e_instr = instr; r.e_npc = npc; r.e_halt = halt;
      return r;
   endfunction

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   task automatic drive(input logic [31:0] addr, input logic ihit, input logic [31:0] load,
                        input logic flush, input logic rdy);
      bus.imemaddr  = addr;
      bus.pc_plus_4 = addr + 32'd4;
      bus.ihit      = ihit;
      bus.imemload  = load;
      bus.flush     = flush;
      bus.de_ready  = rdy;
   endtask

   initial begin
      fetch_entry_t sbq [$];
      logic [31:0]  pc;
      logic [31:0]  ld;
      logic         ih, rdy, fl, mhalt;
      logic         e_ren, e_push, e_pop;

      checks = 0;
      errors = 0;

      //           addr        ihit load          fl rdy ren pce vld instr         npc         halt
      tbl[0]  = v(32'h000, 1, 32'h20010005, 0, 1, 1, 1, 0, 32'h00000000, 32'h000, 0);
      tbl[1]  = v(32'h004, 0, 32'h00000000, 0, 0, 1, 0, 1, 32'h20010005, 32'h004, 0);
      tbl[2]  = v(32'h004, 0, 32'h00000000, 0, 0, 1, 0, 1, 32'h20010005, 32'h004, 0);
      tbl[3]  = v(32'h004, 0, 32'h00000000, 0, 0, 1, 0, 1, 32'h20010005, 32'h004, 0);
      tbl[4]  = v(32'h004, 1, 32'h11111111, 0, 0, 1, 1, 1, 32'h20010005, 32'h004, 0);
      tbl[5]  = v(32'h008, 1, 32'h22222222, 0, 0, 0, 0, 1, 32'h20010005, 32'h004, 0);
      tbl[6]  = v(32'h008, 1, 32'h22222222, 0, 1, 0, 0, 1, 32'h20010005, 32'h004, 0);
      tbl[7]  = v(32'h008, 1, 32'h22222222, 0, 0, 1, 1, 1, 32'h11111111, 32'h008, 0);
      tbl[8]  = v(32'h00C, 1, 32'hDEADBEEF, 1, 1, 0, 1, 1, 32'h11111111, 32'h008, 0);
      tbl[9]  = v(32'h100, 0, 32'h00000000, 0, 1, 1, 0, 0, 32'h11111111, 32'h008, 0);
      tbl[10] = v(32'h100, 1, 32'hFC000000, 0, 0, 1, 1, 0, 32'h11111111, 32'h008, 0);
      tbl[11] = v(32'h104, 1, 32'h33333333, 0, 0, 0, 0, 1, 32'hFC000000, 32'h104, 1);
      tbl[12] = v(32'h104, 1, 32'h33333333, 0, 1, 0, 0, 1, 32'hFC000000, 32'h104, 1);
      tbl[13] = v(32'h104, 0, 32'h00000000, 0, 1, 0, 0, 0, 32'hFC000000, 32'h104, 1);
      tbl[14] = v(32'h104, 0, 32'h00000000, 1, 0, 0, 1, 0, 32'hFC000000, 32'h104, 1);
      tbl[15] = v(32'h200, 1, 32'h44444444, 0, 1, 1, 1, 0, 32'hFC000000, 32'h104, 0);
      tbl[16] = v(32'h204, 1, 32'h55555555, 0, 1, 1, 1, 1, 32'h44444444, 32'h204, 0);
      tbl[17] = v(32'h208, 0, 32'h00000000, 0, 1, 1, 0, 1, 32'h55555555, 32'h208, 0);
      tbl[18] = v(32'h208, 0, 32'h00000000, 0, 0, 1, 0, 0, 32'h55555555, 32'h208, 0);

      // Reset state
      nRST = 1'b0;
      drive(32'h0, 1'b1, 32'h20010005, 1'b0, 1'b0);
      repeat (2) @(posedge CLK);
      #1;
      chk("rst_ren",   {31'b0, bus.imemREN},  32'd0);
      chk("rst_vld",   {31'b0, bus.de_valid}, 32'd0);
      chk("rst_halt",  {31'b0, bus.halted},   32'd0);
      chk("rst_instr", bus.de_instr,          32'd0);
      chk("rst_npc",   bus.de_npc,            32'd0);
      drive(32'h0, 1'b0, 32'h0, 1'b0, 1'b0);
      nRST = 1'b1;

      // Directed cycle table
      for (int i = 0; i < 19; i++) begin
         @(posedge CLK);
         #1;
         drive(tbl[i].addr, tbl[i].ihit, tbl[i].load, tbl[i].flush, tbl[i].rdy);
         @(negedge CLK);
         chk($sformatf("row%0d_ren", i),   {31'b0, bus.imemREN},  {31'b0, tbl[i].e_ren});
         chk($sformatf("row%0d_pcen", i),  {31'b0, bus.pc_en},    {31'b0, tbl[i].e_pcen});
         chk($sformatf("row%0d_vld", i),   {31'b0, bus.de_valid}, {31'b0, tbl[i].e_vld});
         chk($sformatf("row%0d_instr", i), bus.de_instr,          tbl[i].e_instr);
         chk($sformatf("row%0d_npc", i),   bus.de_npc,            tbl[i].e_npc);
         chk($sformatf("row%0d_halt", i),  {31'b0, bus.halted},   {31'b0, tbl[i].e_halt});
         chk($sformatf("row%0d_addr", i),  bus.imemaddr_o,        tbl[i].addr);
      end

      // Asynchronous reset with one entry queued
      @(posedge CLK);
      #1;
      drive(32'h300, 1'b1, 32'h66666666, 1'b0, 1'b0);
      @(posedge CLK);
      #1;
      drive(32'h304, 1'b0, 32'h0, 1'b0, 1'b0);
      chk("mid_vld_before", {31'b0, bus.de_valid}, 32'd1);
      chk("mid_instr_before", bus.de_instr, 32'h66666666);
      #2;
      nRST = 1'b0;
      #1;
      chk("mid_rst_vld",   {31'b0, bus.de_valid}, 32'd0);
      chk("mid_rst_ren",   {31'b0, bus.imemREN},  32'd0);
      chk("mid_rst_instr", bus.de_instr,          32'd0);
      chk("mid_rst_npc",   bus.de_npc,            32'd0);
      @(posedge CLK);
      #1;
      nRST = 1'b1;

      // Randomized run against a queue-based scoreboard
      pc    = 32'h0;
      mhalt = 1'b0;
      sbq.delete();
      for (int c = 0; c < 400; c++) begin
         @(posedge CLK);
         #1;
         ih  = ($urandom_range(0, 3) != 0);
         rdy = ($urandom_range(0, 2) != 0);
         fl  = ($urandom_range(0, 15) == 0);
         ld  = $urandom;
         if ($urandom_range(0, 9) == 0) begin
            ld[31:26] = 6'b111111;
         end else if (ld[31:26] == 6'b111111) begin
            ld[31] = 1'b0;
         end
         drive(pc, ih, ld, fl, rdy);
         @(negedge CLK);
         e_ren  = !mhalt && !fl && (sbq.size() != DEPTH);
         e_push = e_ren && ih;
         e_pop  = (sbq.size() != 0) && rdy && !fl;
         chk("rnd_ren",  {31'b0, bus.imemREN},  {31'b0, e_ren});
         chk("rnd_pcen", {31'b0, bus.pc_en},    {31'b0, e_push | fl});
         chk("rnd_vld",  {31'b0, bus.de_valid}, {31'b0, sbq.size() != 0});
         chk("rnd_halt", {31'b0, bus.halted},   {31'b0, mhalt});
         if (sbq.size() != 0) begin
            chk("rnd_instr", bus.de_instr, sbq[0].instr);
            chk("rnd_npc",   bus.de_npc,   sbq[0].npc);
         end
         if (fl) begin
            sbq.delete();
            mhalt = 1'b0;
            pc = {$urandom_range(0, 16'hFFFF), 2'b00};
         end else begin
            if (e_pop) begin
               void'(sbq.pop_front());
            end
            if (e_push) begin
               sbq.push_back('{instr: ld, npc: pc + 32'd4});
               if (ld[31:26] == 6'b111111) begin
                  mhalt = 1'b1;
               end
               pc = pc + 32'd4;
            end
         end
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/fetch_queue.md
Name: fetch_queue

Overview:
- Instruction-fetch stage directly downstream of the PC block.
- Takes imemaddr/pc_plus_4 from the PC and issues instruction-memory reads to the icache.
- Buffers returned instructions, tagged with their pc_plus_4, in a small FIFO that feeds decode.
- Drives pc_en back to the PC so the PC only advances when a fetch is accepted; squashes the queue on a branch/jump redirect.

Parameters:
- DEPTH, 2, number of queue entries; power of two, at least 2.
- HALT_OP, 6'b111111, opcode that stops further fetching.

Ports:
- CLK  input  1  system clock, rising edge.
- nRST  input  1  asynchronous active-low reset.
- imemaddr  input  32  fetch address from the PC.
- pc_plus_4  input  32  imemaddr+4 from the PC.
- ihit  input  1  icache hit; imemload is valid this cycle.
- imemload  input  32  instruction returned by the icache.
- flush  input  1  redirect from execute/branch resolution; kills queued and in-flight fetches.
- de_ready  input  1  decode accepts the head entry this cycle.
- imemREN  output  1  instruction read request.
- imemaddr_o  output  32  address presented to the icache.
- pc_en  output  1  advance/load enable to the PC.
- de_valid  output  1  head entry valid.
- de_instr  output  32  head instruction.
- de_npc  output  32  head pc_plus_4.
- halted  output  1  HALT_OP fetched; fetching stopped.

Behaviour:
- Reset (async, nRST=0): count=0, rd/wr pointers=0, halted=0, de_valid=0, de_instr=0, de_npc=0, imemREN=0. Storage contents are don't-care.
- imemaddr_o = imemaddr (combinational pass-through).
- imemREN = !halted & !flush & (count != DEPTH). A request is held across cycles until ihit.
- push = imemREN & ihit. On push, write {imemload, pc_plus_4} at wr_ptr; wr_ptr advances mod DEPTH.
- pop = de_valid & de_ready & !flush. On pop, rd_ptr advances mod DEPTH.
- pc_en = push | flush. The PC therefore advances exactly once per accepted instruction, and loads the redirect target on flush.
- count update:
  - +1 on push only.
  - -1 on pop only.
  - unchanged on simultaneous push and pop.
  - count never exceeds DEPTH or goes below 0.
- Full: imemREN=0, no push, even if pop occurs the same cycle. Fetch resumes the following cycle.
- Empty: de_valid=0. de_instr/de_npc hold their last values.
- Latency: ihit in cycle N gives de_valid=1 in cycle N+1 (no bypass).
- de_valid = (count != 0). de_instr/de_npc = entry[rd_ptr] (registered storage read).
- Halt:
  - A push whose imemload[31:26]==HALT_OP sets halted=1 on the next edge.
  - The HALT instruction itself is queued normally.
  - While halted=1: imemREN=0, pc_en=0.
- flush (highest priority):
  - Next edge: count=0, pointers=0, halted=0.
  - A same-cycle ihit is discarded (no push).
  - A same-cycle de_ready pop is ignored.
  - Fetch restarts in the cycle after flush with the PC's new target.
- Reset mid-operation: immediate asynchronous clear to the reset state; no partial entries survive.

Decomposition:
- cpu_types_pkg: add fetch_entry_t (packed struct: word_t instr; word_t npc) and localparam HALT_OP; reuse word_t and opcode_t.
- Port grouping: fetch_if.vh interface with modports fq (this block) and de (decode).
- Sub-module: fetch_fifo, a generic DEPTH-entry fetch_entry_t FIFO with push/pop/clear/full/empty/count. fetch_queue holds the request, halt and flush control around it.

Test Plan:
- Reset then run: imemaddr=0x0, ihit=1, imemload=0x20010005, de_ready=1 -> imemREN=1 and pc_en=1 in cycle 1; de_valid=1, de_instr=0x20010005, de_npc=0x4 in cycle 2.
- Fill with de_ready=0, ihit=1 -> after 2 pushes count=2, imemREN=0, pc_en=0; raising de_ready pops 0x4 first (FIFO order), and imemREN returns the next cycle.
- Miss latency: ihit=0 for 3 cycles -> imemREN stays 1 with address unchanged, pc_en=0, de_valid unchanged; ihit=1 on cycle 4 -> single push.
- Flush with queue holding 2 entries and ihit=1 the same cycle -> pc_en=1, next cycle de_valid=0 and count=0; the discarded imemload never appears at decode.
- HALT: imemload=0xFC000000 pushed -> halted=1 next cycle, imemREN=0; entry still delivered to decode; a later flush clears halted and fetch resumes.
- Assert nRST=0 mid-stream with count=1 -> outputs reach reset values asynchronously before the next CLK edge.
